// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for fetch, same-cycle redirect, training from resolved branches/JALs.
module btb_predictor #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [31:0] upd_pred_pc,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] hit_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic             r_valid   [ENTRIES];
  logic [TAG_W-1:0] r_tag     [ENTRIES];
  logic [31:0]      r_target  [ENTRIES];
  logic             r_is_jump [ENTRIES];
  logic [1:0]       r_ctr     [ENTRIES];

  logic [31:0] r_hit_count;
  logic [31:0] r_mispredict_count;

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic [31:0]         w_f_pc4;
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_W-1:0]    w_u_tag;
  logic [31:0]         w_u_pc4;
  logic [31:0]         w_u_actual;
  logic                w_u_hit;
  logic                w_train;
  logic                w_alloc;
  logic                w_wr_target;
  logic                w_wr_ctr;
  logic [1:0]          w_ctr_nxt;
  logic                w_unused_pc_lsbs;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  assign w_f_idx = fetch_pc[IDX_BITS+1:2];
  assign w_f_tag = fetch_pc[31:IDX_BITS+2];
  assign w_f_pc4 = fetch_pc + 32'd4;
  assign w_u_idx = upd_pc[IDX_BITS+1:2];
  assign w_u_tag = upd_pc[31:IDX_BITS+2];
  assign w_u_pc4 = upd_pc + 32'd4;
  assign w_u_actual = upd_taken ? upd_target : w_u_pc4;
  assign w_unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup; reset clears valid asynchronously so a held reset forces a miss.
  always_comb begin
    pred_hit   = 1'b0;
    pred_taken = 1'b0;
    pred_pc    = w_f_pc4;
    if (r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag)) begin
      pred_hit   = 1'b1;
      pred_taken = r_is_jump[w_f_idx] | r_ctr[w_f_idx][1];
    end else begin
      pred_hit   = 1'b0;
      pred_taken = 1'b0;
    end
    if (pred_taken) begin
      pred_pc = r_target[w_f_idx];
    end else begin
      pred_pc = w_f_pc4;
    end
  end

  // Resolution compare against the prediction carried down the pipe.
  always_comb begin
    mispredict = 1'b0;
    correct_pc = w_u_pc4;
    if (upd_valid) begin
      correct_pc = w_u_actual;
      mispredict = (w_u_actual != upd_pred_pc);
    end else begin
      correct_pc = w_u_pc4;
      mispredict = 1'b0;
    end
  end

  // Training decode: JALR and non-control instructions never reach the table.
  always_comb begin
    w_train     = upd_valid & (upd_is_branch | upd_is_jump);
    w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_alloc     = 1'b0;
    w_wr_target = 1'b0;
    w_wr_ctr    = 1'b0;
    w_ctr_nxt   = r_ctr[w_u_idx];
    if (w_train && w_u_hit) begin
      if (upd_is_jump) begin
        w_wr_target = 1'b1;
        w_wr_ctr    = 1'b1;
        w_ctr_nxt   = 2'b11;
      end else begin
        w_wr_target = upd_taken;
        w_wr_ctr    = 1'b1;
        w_ctr_nxt   = sat_ctr(r_ctr[w_u_idx], upd_taken);
      end
    end else if (w_train && upd_taken) begin
      w_alloc     = 1'b1;
      w_wr_target = 1'b1;
      w_wr_ctr    = 1'b1;
      w_ctr_nxt   = upd_is_jump ? 2'b11 : 2'b10;
    end else begin
      w_alloc     = 1'b0;
      w_wr_target = 1'b0;
      w_wr_ctr    = 1'b0;
    end
  end

  // Table state; tag/target are not cleared by reset but still hold while it is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]   <= 1'b0;
        r_is_jump[i] <= 1'b0;
        r_ctr[i]     <= 2'b00;
      end
    end else begin
      if (w_alloc) begin
        r_valid[w_u_idx]   <= 1'b1;
        r_tag[w_u_idx]     <= w_u_tag;
        r_is_jump[w_u_idx] <= upd_is_jump;
      end
      if (w_wr_target) begin
        r_target[w_u_idx] <= upd_target;
      end
      if (w_wr_ctr) begin
        r_ctr[w_u_idx] <= w_ctr_nxt;
      end
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count        <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (fetch_valid && pred_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign hit_count        = r_hit_count;
  assign mispredict_count = r_mispredict_count;

endmodule
